writeback_port_arbiter: RTL

//  Shares the single register-file write port between the in-order writeback stage and
//  one long-latency unit (MUL/DIV) that returns results out of order.
//  - Buffers returning long-latency results in a small FIFO.
//  - Keeps a pending-destination scoreboard.
//  - Raises a decode-stage hazard for any instruction that touches a pending register.
//  - Sits between writeback_cycle (ResultW) and the register file write port.

---
 rtl/writeback_port_arbiter_pkg.sv | 20 ++
 rtl/wb_result_fifo.sv | 52 +++++
 rtl/writeback_port_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/writeback_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter: result entry layout and
// write-port source selector.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_SRC_NONE,
    WB_SRC_PIPE,
    WB_SRC_LL
  } wb_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small circular buffer holding long-latency results until the write port is free.
// Pointers and count are reset; the storage array is data and is not.
module wb_result_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign head  = mem[rd_ptr];
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_port_arbiter.sv
// Shares the register-file write port between the in-order writeback stage and a
// buffered long-latency unit; tracks pending destinations for decode hazards.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module writeback_port_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteW,
  input  logic [4:0]  RD_W,
  input  logic [31:0] ResultW,
  input  logic        ll_valid,
  input  logic [4:0]  ll_rd,
  input  logic [31:0] ll_data,
  output logic        ll_ready,
  input  logic        issue_ll,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  RS1_D,
  input  logic [4:0]  RS2_D,
  input  logic [4:0]  RD_D,
  output logic        hazard_ll,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                slot_busy;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W-1:0]    fifo_level_unused;
  wb_entry_t           push_entry;
  wb_entry_t           head;
  wb_src_e             src;
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  assign slot_busy  = RegWriteW && (RD_W != '0);
  assign ll_ready   = !fifo_full;
  assign push       = ll_valid && !fifo_full;
  assign push_entry = '{rd: ll_rd, data: ll_data};
  assign pop        = (src == WB_SRC_LL);

  wb_result_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_level_unused)
  );

  // Pipeline always owns the port when it writes a real register; x0 writes are free slots.
  always_comb begin
    src = WB_SRC_NONE;
    if (rst) begin
      src = WB_SRC_NONE;
    end else if (slot_busy) begin
      src = WB_SRC_PIPE;
    end else if (!fifo_empty) begin
      src = WB_SRC_LL;
    end
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    case (src)
      WB_SRC_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = RD_W;
        rf_wdata = ResultW;
      end
      WB_SRC_LL: begin
        rf_we    = (head.rd != '0);
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  // A new issue to a register overrides the clear from a same-cycle pop of an older result.
  always_comb begin
    pending_nxt = pending;
    if (pop) begin
      pending_nxt[head.rd] = 1'b0;
    end
    if (issue_ll && (issue_rd != '0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign hazard_ll = pending[RS1_D] | pending[RS2_D] | pending[RD_D];

`ifdef WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0] starve_cnt;
  logic            stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else if (pop) begin
      starve_cnt <= '0;
      stall_q    <= 1'b0;
    end else begin
      if (!fifo_empty && (starve_cnt != SC_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
      if (starve_cnt == SC_W'(STARVE_LIMIT)) begin
        stall_q <= 1'b1;
      end
    end
  end

  assign stall_pipe = stall_q;
`else
  assign stall_pipe = 1'b0;
`endif

endmodule
